muldiv_sequencer: RTL and testbench

//  Iterative multi-cycle sequencer for the RV32M MUL/DIV/REM ops (R-type, funct7=0000001).
//  - Sits beside the ALU in EX; the pipeline stalls on busy.
//  - Runs one shift-add (multiply) or restoring-subtract (divide) step per cycle.
//  - Returns one result with a single-cycle done pulse.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 143 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the iterative MUL/DIV/REM sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output ready, busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV/REM sequencer: one shift-add or restoring-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2:0]         op;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   result_q;

    // Request decode: magnitudes and sign flags of the incoming operands.
    logic               a_signed, b_signed, in_sign_a, in_sign_b, in_div, in_div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               early;
    logic [2*WIDTH-1:0] acc_init;

    always_comb begin
        in_div      = bus.funct3[2];
        a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        in_sign_a   = a_signed && bus.op_a[WIDTH-1];
        in_sign_b   = b_signed && bus.op_b[WIDTH-1];
        mag_a       = in_sign_a ? -bus.op_a : bus.op_a;
        mag_b       = in_sign_b ? -bus.op_b : bus.op_b;
        in_div_zero = in_div && (bus.op_b == '0);
        early       = 1'b0;
        acc_init    = {{WIDTH{1'b0}}, mag_a};
`ifdef MULDIV_EARLY_OUT_EN
        // Preload the accumulator with exactly what the full iteration would leave behind.
        if (in_div_zero) begin
            early    = 1'b1;
            acc_init = {mag_a, {WIDTH{1'b1}}};
        end else if (in_div && !bus.funct3[0] && bus.op_a == {1'b1, {(WIDTH-1){1'b0}}} &&
                     bus.op_b == '1) begin
            early    = 1'b1;
            acc_init = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
        end else if (!in_div && (bus.op_a == '0 || bus.op_b == '0)) begin
            early    = 1'b1;
            acc_init = '0;
        end
`endif
    end

    // One iteration: accumulator high half is the partial product or the running remainder.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     trial_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        trial      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial_diff = trial - {1'b0, opnd};
        if (!op[2]) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (trial >= {1'b0, opnd}) begin
            acc_step = {trial_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and word selection.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_val;

    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quo  = ((sign_a ^ sign_b) && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 fix_val = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = quo;
            default:                fix_val = rem;
        endcase
    end

    // NOTE: the reset is synchronous and clears the datapath registers too, so a reset
    // mid-operation leaves nothing stale behind for the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            op       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op       <= bus.funct3;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        div_zero <= in_div_zero;
                        opnd     <= mag_b;
                        acc      <= acc_init;
                        count    <= CW'(WIDTH - 1);
                        state    <= early ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    if (count == '0) state <= FIX;
                    else             count <= count - 1'b1;
                end
                FIX: begin
                    result_q <= fix_val;
                    state    <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = (state == IDLE);
    assign bus.busy   = (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, flush/reset/hold sequences, random ops.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Architectural RV32M result computed with wide integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'h0, b})); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2] && b == 0) return 2;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        if (!f3[2] && (a == 0 || b == 0)) return 2;
`endif
        return W + 2;
    endfunction

    // Called at a falling edge while idle; returns at the falling edge of the idle cycle after done.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int n;
        bit busy_ok;
        check({name, " ready"}, 32'(bus.ready), 32'd1);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        @(negedge clk);
        n       = 1;
        busy_ok = 1'b1;
        if (hold) begin
            bus.op_a   = ~a;
            bus.funct3 = f3 ^ 3'b001;
        end else begin
            bus.start = 1'b0;
        end
        while (!bus.done && n < 100) begin
            if (!bus.busy || bus.ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({name, " latency"}, 32'(n), 32'(lat_model(f3, a, b)));
        check({name, " result"}, bus.result, exp);
        check({name, " busy"}, 32'(busy_ok && !bus.busy), 32'd1);
        @(negedge clk);
        check({name, " post"}, {29'h0, bus.ready, bus.busy, bus.done}, 32'b100);
        last_exp = exp;
    endtask

    vec_t vecs[$];

    initial begin
        int          n;
        bit          seen;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [31:0] pool [6];

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {29'h0, bus.ready, bus.busy, bus.done}, 32'b100);
        check("reset result", bus.result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs = '{
            '{"mul 7*-3",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{"mulh min*min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{"mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{"mulhsu -1*2",   3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF},
            '{"div -7/2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
            '{"rem -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
            '{"divu 100/7",    3'd5, 32'd100,       32'd7,         32'd14},
            '{"remu 100/7",    3'd7, 32'd100,       32'd7,         32'd2},
            '{"div 5/0",       3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF},
            '{"remu 5/0",      3'd7, 32'd5,         32'd0,         32'd5},
            '{"div -5/0",      3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
            '{"rem -5/0",      3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
            '{"div ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{"rem ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
            '{"mul 0*5",       3'd0, 32'd0,         32'd5,         32'h0}
        };
        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        // start held high through the whole operation must yield exactly one result.
        run_op("held start", 3'd5, 32'd1000, 32'd3, 32'd333, 1'b1);

        // Flush a divide at cycle c+10.
        bus.start  = 1'b1;
        bus.funct3 = 3'd4;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (n < 10) begin
            if (bus.done) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush state", {29'h0, bus.ready, bus.busy, bus.done}, 32'b100);
        check("flush no done", 32'(seen), 32'd0);
        check("flush result kept", bus.result, last_exp);
        run_op("after flush", 3'd4, 32'd1000, 32'd7, 32'd142, 1'b0);

        // Synchronous reset at cycle c+20.
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.op_a   = 32'hDEAD_BEEF;
        bus.op_b   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midop reset state", {29'h0, bus.ready, bus.busy, bus.done}, 32'b100);
        check("midop reset result", bus.result, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            if (bus.done || !bus.ready) seen = 1'b1;
            @(negedge clk);
        end
        check("midop reset no done", 32'(seen), 32'd0);

        // Random operations against the arithmetic model, biased towards corner operands.
        pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            pool[5] = $urandom;
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
            run_op("rand", f3, a, b, ref_res(f3, a, b), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
